// File: rtl/nios_mul_result_stage.sv
// nios_mul_result_stage
// Reduction stage behind the 16x16 multiplier cell. It folds the three
// partial products into the low 32 bits of a 32x32 product across two
// register stages. A destination tag travels with each product to writeback.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready depends combinationally on out_ready, so back-pressure
// reaches the multiplier cell in the same cycle. out_valid/out_result/out_tag
// are held stable while out_valid=1 and out_ready=0. flush drops everything
// held, and also drops any input accepted on the same edge.
module nios_mul_result_stage #(
    parameter int TAG_W  = 5,
    parameter int PART_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_p1,
    input  logic [31:0]      in_p2,
    input  logic [31:0]      in_p3,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       occupancy
);

    // The reduction is hard-wired to a 16-bit split of the operands.
    generate
        if (PART_W != 16) begin : g_part_w_check
            $error("nios_mul_result_stage: PART_W must be 16");
        end
    endgenerate

    logic             v1;
    logic             v2;
    logic [31:0]      p1_q;
    logic [15:0]      mid_q;
    logic [TAG_W-1:0] tag1_q;
    logic [31:0]      result_q;
    logic [TAG_W-1:0] tag2_q;

    logic             s2_free;
    logic             s1_adv;
    logic             accept;
    logic             out_fire;
    logic [15:0]      mid_sum;

    // The upper halves of p2/p3 are shifted past bit 31 and never contribute.
    logic             unused_upper;
    assign unused_upper = ^{in_p2[31:16], in_p3[31:16]};

    assign s2_free  = !v2 || out_ready;
    assign s1_adv   = v1 && s2_free;
    assign in_ready = !v1 || s1_adv;
    assign accept   = in_valid && in_ready;
    assign out_fire = v2 && out_ready;

    // Only the low half of the middle-term sum survives the 16-bit shift.
    assign mid_sum  = in_p2[PART_W-1:0] + in_p3[PART_W-1:0];

    assign out_valid  = v2;
    assign out_result = result_q;
    assign out_tag    = tag2_q;
    assign occupancy  = {1'b0, v1} + {1'b0, v2};

    // Stage valid bits: flush has priority over accept and advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (accept) begin
                v1 <= 1'b1;
            end else if (s1_adv) begin
                v1 <= 1'b0;
            end
            if (s1_adv) begin
                v2 <= 1'b1;
            end else if (out_fire) begin
                v2 <= 1'b0;
            end
        end
    end

    // S1 data: capture p1 and the truncated middle sum on every accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p1_q   <= '0;
            mid_q  <= '0;
            tag1_q <= '0;
        end else if (accept) begin
            p1_q   <= in_p1;
            mid_q  <= mid_sum;
            tag1_q <= in_tag;
        end
    end

    // S2 data: final 32-bit add, carry out of bit 31 discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            tag2_q   <= '0;
        end else if (s1_adv) begin
            result_q <= p1_q + {mid_q, {PART_W{1'b0}}};
            tag2_q   <= tag1_q;
        end
    end

endmodule

// File: tb/tb_nios_mul_result_stage.sv
// tb_nios_mul_result_stage
// Operands a,b are randomised, split into the three 16x16 partial products
// the multiplier cell would produce, and the expected result is simply the
// low 32 bits of a*b. The reference holds in-flight products in a queue with
// an age counter: the oldest product becomes visible one edge after the edge
// that accepted it. The stage accepts while fewer than two products are held,
// or while writeback is ready.
module tb_nios_mul_result_stage;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_p1;
  logic [31:0]      in_p2;
  logic [31:0]      in_p3;
  logic [TAG_W-1:0] in_tag;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       occupancy;

  int checks   = 0;
  int failures = 0;

  logic [31:0]      exp_q[$];
  logic [TAG_W-1:0] tag_q[$];
  int               age_q[$];

  bit mon_en   = 1'b0;
  int act_hs   = 0;
  bit last_acc = 1'b0;

  nios_mul_result_stage #(.TAG_W(TAG_W), .PART_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_p1      (in_p1),
    .in_p2      (in_p2),
    .in_p3      (in_p3),
    .in_tag     (in_tag),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .occupancy  (occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic bit model_ov();
    return (exp_q.size() > 0) && (age_q[0] >= 1);
  endfunction

  function automatic void model_clear();
    exp_q.delete();
    tag_q.delete();
    age_q.delete();
  endfunction

  // scoreboard: every cycle, the visible output must match the oldest product
  always @(negedge clk) begin
    #4;
    if (mon_en && (reset === 1'b0)) begin
      checks++;
      if (out_valid !== model_ov()) begin
        failures++;
        $display("FAIL sb_out_valid: got %0b expected %0b at %0t", out_valid, model_ov(), $time);
      end
      checks++;
      if (occupancy !== 2'(exp_q.size())) begin
        failures++;
        $display("FAIL sb_occupancy: got %0d expected %0d at %0t", occupancy, exp_q.size(), $time);
      end
      checks++;
      if (in_ready !== ((exp_q.size() < 2) || (out_ready === 1'b1))) begin
        failures++;
        $display("FAIL sb_in_ready: got %0b at %0t", in_ready, $time);
      end
      if (model_ov()) begin
        checks++;
        if (out_result !== exp_q[0]) begin
          failures++;
          $display("FAIL sb_result: got %08h expected %08h at %0t", out_result, exp_q[0], $time);
        end
        checks++;
        if (out_tag !== tag_q[0]) begin
          failures++;
          $display("FAIL sb_tag: got %0d expected %0d at %0t", out_tag, tag_q[0], $time);
        end
      end
    end
  end

  // driver: present one cycle of stimulus and advance the reference on the edge
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] t, input bit ordy, input bit fl);
    logic [31:0] alo, ahi, blo, bhi, prod;
    bit m_rdy, m_acc, m_hs;
    alo = {16'h0, a[15:0]};
    ahi = {16'h0, a[31:16]};
    blo = {16'h0, b[15:0]};
    bhi = {16'h0, b[31:16]};
    prod = a * b;
    in_valid  = v;
    in_p1     = alo * blo;
    in_p2     = alo * bhi;
    in_p3     = ahi * blo;
    in_tag    = t;
    out_ready = ordy;
    flush     = fl;
    #1;
    m_rdy = (exp_q.size() < 2) || ordy;
    m_acc = v && m_rdy;
    m_hs  = model_ov() && ordy;
    if (out_valid === 1'b1 && out_ready === 1'b1) act_hs++;
    last_acc = m_acc;
    @(posedge clk);
    if (fl) begin
      model_clear();
    end else begin
      if (m_hs) begin
        void'(exp_q.pop_front());
        void'(tag_q.pop_front());
        void'(age_q.pop_front());
      end
      foreach (age_q[i]) age_q[i]++;
      if (m_acc) begin
        exp_q.push_back(prod);
        tag_q.push_back(t);
        age_q.push_back(0);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++;
    if (out_result !== 32'h0) begin failures++; $display("FAIL reset_out_result: got %08h expected 0", out_result); end
    checks++;
    if (out_tag !== '0) begin failures++; $display("FAIL reset_out_tag: got %0d expected 0", out_tag); end
    checks++;
    if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    step(1'b1, 32'h00010003, 32'h00020005, 5'd7, 1'b1, 1'b0);
    #2;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid: got %0b expected 0", out_valid); end
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    #2;
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid: got %0b expected 1", out_valid); end
    checks++;
    if (out_result !== 32'h000B000F) begin failures++; $display("FAIL basic_result: got %08h expected 000b000f", out_result); end
    checks++;
    if (out_tag !== 5'd7) begin failures++; $display("FAIL basic_tag: got %0d expected 7", out_tag); end
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    #2;
    checks++;
    if (occupancy !== 2'd0) begin failures++; $display("FAIL basic_drain: got %0d expected 0", occupancy); end
  endtask

  task automatic test_wrap();
    step(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    #2;
    checks++;
    if (out_result !== 32'h00000001) begin failures++; $display("FAIL wrap_result: got %08h expected 00000001", out_result); end
    checks++;
    if (out_tag !== 5'd31) begin failures++; $display("FAIL wrap_tag: got %0d expected 31", out_tag); end
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int hs0;
    hs0 = act_hs;
    for (int k = 1; k <= 6; k++) begin
      step(k <= 4, $urandom, $urandom, TAG_W'(k), 1'b1, 1'b0);
      #2;
      checks++;
      if (out_valid !== ((k >= 2) && (k <= 5))) begin
        failures++;
        $display("FAIL b2b_valid_cycle%0d: got %0b", k, out_valid);
      end
    end
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (act_hs - hs0 != 4) begin failures++; $display("FAIL b2b_count: got %0d expected 4", act_hs - hs0); end
  endtask

  task automatic test_stall();
    int hs0;
    logic [31:0] held;
    logic [31:0] a2, b2;
    hs0 = act_hs;
    a2 = $urandom;
    b2 = $urandom;
    step(1'b1, $urandom, $urandom, 5'd10, 1'b0, 1'b0);
    step(1'b1, $urandom, $urandom, 5'd11, 1'b0, 1'b0);
    #2;
    checks++;
    if (occupancy !== 2'd2) begin failures++; $display("FAIL stall_occupancy: got %0d expected 2", occupancy); end
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready: got %0b expected 0", in_ready); end
    held = out_result;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, a2, b2, 5'd12, 1'b0, 1'b0);
      #2;
      checks++;
      if (out_result !== held) begin failures++; $display("FAIL stall_stable: got %08h expected %08h", out_result, held); end
      checks++;
      if (occupancy !== 2'd2) begin failures++; $display("FAIL stall_hold: got %0d expected 2", occupancy); end
    end
    step(1'b1, a2, b2, 5'd12, 1'b1, 1'b0);
    checks++;
    if (last_acc !== 1'b1 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL stall_third_accept: held %0d expected 2", exp_q.size());
    end
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    #2;
    checks++;
    if (act_hs - hs0 != 3) begin failures++; $display("FAIL stall_delivered: got %0d expected 3", act_hs - hs0); end
  endtask

  task automatic test_flush();
    int hs0;
    step(1'b1, $urandom, $urandom, 5'd20, 1'b0, 1'b0);
    step(1'b1, $urandom, $urandom, 5'd21, 1'b0, 1'b0);
    #2;
    checks++;
    if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_pre_occ: got %0d expected 2", occupancy); end
    hs0 = act_hs;
    step(1'b1, $urandom, $urandom, 5'd22, 1'b0, 1'b1);
    #2;
    checks++;
    if (occupancy !== 2'd0) begin failures++; $display("FAIL flush_occ: got %0d expected 0", occupancy); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid: got %0b expected 0", out_valid); end
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    checks++;
    if (act_hs != hs0) begin failures++; $display("FAIL flush_leak: got %0d outputs expected 0", act_hs - hs0); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom, TAG_W'($urandom),
           $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    for (int k = 0; k < 4; k++) step(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
    #2;
    checks++;
    if (occupancy !== 2'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain: got occupancy %0d expected 0 (model %0d)", occupancy, exp_q.size());
    end
  endtask

  task automatic test_async_reset();
    step(1'b1, $urandom, $urandom, 5'd3, 1'b0, 1'b0);
    step(1'b1, $urandom, $urandom, 5'd4, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    checks++;
    if (occupancy !== 2'd2) begin failures++; $display("FAIL areset_pre_occ: got %0d expected 2", occupancy); end
    mon_en = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid: got %0b expected 0", out_valid); end
    checks++;
    if (occupancy !== 2'd0) begin failures++; $display("FAIL areset_occ: got %0d expected 0", occupancy); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL areset_in_ready: got %0b expected 1", in_ready); end
    model_clear();
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    step(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_p1     = '0;
    in_p2     = '0;
    in_p3     = '0;
    in_tag    = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_flush();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
